prm_edge_mask_accum: RTL and testbench
======================================

Name: prm_edge_mask_accum

Overview:
- Sequencing stage directly upstream and downstream of the bank of per-edge obstacle-logic checkers.
- Accepts a stream of 15-bit obstacle cell codes (one frame = one obstacle scan) and presents each code to the checker bank on its A..O inputs.
- Samples the bank's NUM_EDGES-wide edge_mask vector and ORs it into a per-edge blocked accumulator.
- At frame end, hands the final blocked/free edge map to the PRM graph updater over a valid/ready handshake.

Parameters:
- NUM_EDGES, 64, number of checker instances (width of mask vectors).
- CODE_W, 15, obstacle code width (checker inputs A..O; bit 0 = A, bit 14 = O).
- CNT_W, 16, width of the per-frame point counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous frame abort; highest priority after rst.
- pt_valid  in  1  obstacle code valid.
- pt_ready  out  1  block can accept a code.
- pt_code  in  CODE_W  obstacle cell code.
- pt_last  in  1  code is the last of the frame.
- chk_code  out  CODE_W  registered code driven to all checker inputs.
- chk_mask  in  NUM_EDGES  combinational edge_mask outputs of the checker bank.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_blocked  out  NUM_EDGES  1 = edge hit by at least one code in the frame.
- out_count  out  CNT_W  codes accepted in the frame.
- out_any  out  1  OR-reduce of out_blocked.

Behaviour:
- One clock domain.
- Reset: rst is asynchronous, active-high. All registers clear: state=IDLE, chk_code=0, s1_valid=0, acc=0, count=0. Outputs at reset: out_valid=0, out_blocked=0, out_count=0, out_any=0. pt_ready reflects IDLE, so it is 1 once rst deasserts.
- FSM states:
  - IDLE: no frame in progress; acc=0.
  - ACCUM: frame in progress.
  - DRAIN: last code accepted; its mask is not yet sampled.
  - DONE: result held.
- pt_ready = 1 in IDLE or ACCUM, 0 in DRAIN or DONE. It is registered-state derived; there is no combinational path from pt_valid.
- Accept = pt_valid & pt_ready.
  - On accept at edge T: chk_code<=pt_code, s1_valid<=1, count<=count+1 (saturate at 2^CNT_W-1).
  - Transitions on accept: IDLE->ACCUM if !pt_last; IDLE or ACCUM->DRAIN if pt_last.
  - No accept: s1_valid<=0; chk_code holds.
- Stage 2: at the edge after a code is registered (T+1), if s1_valid then acc<=acc|chk_mask. chk_mask is sampled exactly once per accepted code.
- DRAIN->DONE at the same edge the last code's mask is ORed. out_valid rises at T+2 relative to the accepting edge of the last code.
- Throughput is one code per clock while pt_valid is held. Back-to-back accepts pipeline with no bubbles.
- DONE outputs: out_valid=1, out_blocked=acc, out_count=count, out_any=|acc. These hold stable until out_valid&out_ready.
- On out_ready in DONE: next state IDLE; acc, count and s1_valid clear. pt_ready is 1 from the following cycle. There is no same-cycle accept of a new frame.
- out_blocked, out_count and out_any read 0 outside DONE.
- Single-code frame (first code has pt_last=1): IDLE->DRAIN->DONE, count=1.
- abort = 1: next state IDLE; acc, count and s1_valid clear; out_valid drops. A concurrent accept or out_ready is ignored. chk_code holds.
- Counter saturates; acc is unaffected by saturation.
- The checker bank is purely combinational and sees a registered input. A full cycle of settling is available between chk_code update and mask sampling.

Test Plan:
- Bench model: NUM_EDGES=8, chk_mask = chk_code[7:0].
- Reset check: assert rst mid-frame after 3 codes -> out_valid=0, out_blocked=0, out_count=0 immediately (async); after deassert pt_ready=1 and the next frame starts clean.
- Single-code frame: send 0x0005 with pt_last, out_ready=1 -> out_valid high exactly 2 cycles after the accept, out_blocked=8'h05, out_count=1, out_any=1, one-cycle pulse.
- Back-to-back frame: send 0x0001, 0x0010, 0x0080(last) on consecutive cycles -> pt_ready stays 1 for all three, then 0. Result: out_blocked=8'h91, out_count=3.
- Backpressure: same frame with out_ready=0 for 5 cycles -> outputs stable and pt_ready=0 throughout. Release out_ready -> next cycle state IDLE and pt_ready=1.
- All-free frame: codes 0x0100, 0x7F00 (last) -> out_blocked=0, out_any=0, out_count=2.
- Abort: abort asserted on the same cycle as an accept with pt_last=1 -> no result produced, and the next frame's out_count starts at 1. Saturation: CNT_W=2 with 5 codes -> out_count=3.

Source files
------------

// File: rtl/prm_edge_mask_accum_if.sv
// Handshake and checker-bank bundle between the obstacle stream, the edge
// checker bank and the PRM graph updater.
interface prm_edge_mask_accum_if #(
  parameter int unsigned NUM_EDGES = 64,
  parameter int unsigned CODE_W    = 15,
  parameter int unsigned CNT_W     = 16
) ();
  logic                 pt_valid;
  logic                 pt_ready;
  logic [CODE_W-1:0]    pt_code;
  logic                 pt_last;
  logic [CODE_W-1:0]    chk_code;
  logic [NUM_EDGES-1:0] chk_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_EDGES-1:0] out_blocked;
  logic [CNT_W-1:0]     out_count;
  logic                 out_any;

  modport master (
    output pt_valid, pt_code, pt_last, chk_mask, out_ready,
    input  pt_ready, chk_code, out_valid, out_blocked, out_count, out_any
  );

  modport slave (
    input  pt_valid, pt_code, pt_last, chk_mask, out_ready,
    output pt_ready, chk_code, out_valid, out_blocked, out_count, out_any
  );
endinterface

// File: rtl/prm_edge_mask_accum.sv
// Feeds obstacle codes to the edge checker bank, ORs the returned edge masks
// per frame and hands the blocked-edge map to the graph updater.
module prm_edge_mask_accum #(
  parameter int unsigned NUM_EDGES = 64,
  parameter int unsigned CODE_W    = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  prm_edge_mask_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t               state;
  logic                 s1_valid;
  logic [NUM_EDGES-1:0] acc;
  logic [CNT_W-1:0]     count;
  logic [CODE_W-1:0]    chk_code;
  logic                 pt_ready;
  logic                 out_valid;
  logic [NUM_EDGES-1:0] out_blocked;
  logic [CNT_W-1:0]     out_count;
  logic                 out_any;

  logic                 accept_c;
  logic                 handshake_c;
  logic [CNT_W-1:0]     count_inc_c;

  assign accept_c    = bus.pt_valid & pt_ready;
  assign handshake_c = out_valid & bus.out_ready;
  assign count_inc_c = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  assign bus.pt_ready    = pt_ready;
  assign bus.chk_code    = chk_code;
  assign bus.out_valid   = out_valid;
  assign bus.out_blocked = out_blocked;
  assign bus.out_count   = out_count;
  assign bus.out_any     = out_any;

  // Stage 1 registers the code for the bank; stage 2 folds the bank's mask
  // one cycle later. Result outputs trail entry into DONE by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s1_valid    <= 1'b0;
      acc         <= '0;
      count       <= '0;
      chk_code    <= '0;
      pt_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_blocked <= '0;
      out_count   <= '0;
      out_any     <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      s1_valid    <= 1'b0;
      acc         <= '0;
      count       <= '0;
      pt_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_blocked <= '0;
      out_count   <= '0;
      out_any     <= 1'b0;
    end else begin
      s1_valid    <= accept_c;
      out_valid   <= 1'b0;
      out_blocked <= '0;
      out_count   <= '0;
      out_any     <= 1'b0;

      if (accept_c) begin
        chk_code <= bus.pt_code;
        count    <= count_inc_c;
      end

      if (s1_valid) begin
        acc <= acc | bus.chk_mask;
      end

      case (state)
        IDLE, ACCUM: begin
          if (accept_c) begin
            if (bus.pt_last) begin
              state    <= DRAIN;
              pt_ready <= 1'b0;
            end else begin
              state    <= ACCUM;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          if (handshake_c) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            s1_valid <= 1'b0;
            pt_ready <= 1'b1;
          end else begin
            out_valid   <= 1'b1;
            out_blocked <= acc;
            out_count   <= count;
            out_any     <= |acc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed and randomized frames against an OR-of-codes reference model,
// with the checker bank modelled as mask = chk_code[7:0].
module tb_prm_edge_mask_accum;

  localparam int unsigned NE = 8;
  localparam int unsigned CW = 15;

  logic clk = 1'b0;
  logic rst;
  logic abort;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] fq[$];

  prm_edge_mask_accum_if #(.NUM_EDGES(NE), .CODE_W(CW), .CNT_W(16)) bus ();
  prm_edge_mask_accum_if #(.NUM_EDGES(NE), .CODE_W(CW), .CNT_W(2))  sbus ();

  assign bus.chk_mask  = bus.chk_code[7:0];
  assign sbus.chk_mask = sbus.chk_code[7:0];

  prm_edge_mask_accum #(.NUM_EDGES(NE), .CODE_W(CW), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .bus   (bus)
  );

  prm_edge_mask_accum #(.NUM_EDGES(NE), .CODE_W(CW), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .bus   (sbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the queued codes, optionally with idle gaps, last code flagged.
  task automatic send_codes(input bit mark_last, input bit gaps);
    for (int i = 0; i < fq.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pt_valid = 1'b0;
        step();
        chk("gap_ready", 64'(bus.pt_ready), 64'(1));
        chk("gap_valid", 64'(bus.out_valid), 64'(0));
      end
      bus.pt_valid = 1'b1;
      bus.pt_code  = fq[i];
      bus.pt_last  = mark_last && (i == fq.size() - 1);
      chk("ready_at_accept", 64'(bus.pt_ready), 64'(1));
      step();
    end
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
  endtask

  // Full frame: send, check result timing/content, hold, release.
  task automatic run_frame(input int hold, input bit gaps);
    logic [7:0] eb;
    int ec;
    eb = '0;
    foreach (fq[i]) eb = eb | fq[i][7:0];
    ec = fq.size();
    send_codes(1'b1, gaps);
    chk("drain_ready", 64'(bus.pt_ready), 64'(0));
    chk("drain_valid", 64'(bus.out_valid), 64'(0));
    chk("chk_code_last", 64'(bus.chk_code), 64'(fq[fq.size()-1]));
    step();
    chk("settle_valid", 64'(bus.out_valid), 64'(0));
    chk("settle_blocked", 64'(bus.out_blocked), 64'(0));
    step();
    chk("res_valid", 64'(bus.out_valid), 64'(1));
    chk("res_blocked", 64'(bus.out_blocked), 64'(eb));
    chk("res_count", 64'(bus.out_count), 64'(ec));
    chk("res_any", 64'(bus.out_any), 64'(eb != 8'h00));
    chk("res_ready", 64'(bus.pt_ready), 64'(0));
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_blocked", 64'(bus.out_blocked), 64'(eb));
      chk("hold_count", 64'(bus.out_count), 64'(ec));
      chk("hold_ready", 64'(bus.pt_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rel_valid", 64'(bus.out_valid), 64'(0));
    chk("rel_ready", 64'(bus.pt_ready), 64'(1));
    chk("rel_blocked", 64'(bus.out_blocked), 64'(0));
    chk("rel_count", 64'(bus.out_count), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    bus.pt_valid = 1'b0; bus.pt_code = '0; bus.pt_last = 1'b0; bus.out_ready = 1'b0;
    sbus.pt_valid = 1'b0; sbus.pt_code = '0; sbus.pt_last = 1'b0; sbus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_blocked", 64'(bus.out_blocked), 64'(0));
    chk("rst_count", 64'(bus.out_count), 64'(0));
    chk("rst_any", 64'(bus.out_any), 64'(0));
    chk("rst_chk_code", 64'(bus.chk_code), 64'(0));
    chk("rst_ready", 64'(bus.pt_ready), 64'(1));

    // Single-code frame, consumer always ready.
    fq = '{15'h0005};
    run_frame(0, 1'b0);

    // Back-to-back three-code frame, then with 5 cycles of backpressure.
    fq = '{15'h0001, 15'h0010, 15'h0080};
    run_frame(0, 1'b0);
    run_frame(5, 1'b0);

    // Frame whose codes hit no modelled edge.
    fq = '{15'h0100, 15'h7F00};
    run_frame(1, 1'b0);

    // Reset mid-frame after three codes.
    fq = '{15'h0001, 15'h0002, 15'h0004};
    send_codes(1'b0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_count", 64'(bus.out_count), 64'(0));
    chk("midrst_chk_code", 64'(bus.chk_code), 64'(0));
    step();
    rst = 1'b0;
    step();
    chk("midrst_ready", 64'(bus.pt_ready), 64'(1));
    fq = '{15'h0003};
    run_frame(0, 1'b0);

    // Reset while a result is being held.
    fq = '{15'h0055};
    send_codes(1'b1, 1'b0);
    step();
    step();
    chk("donerst_pre_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("donerst_valid", 64'(bus.out_valid), 64'(0));
    chk("donerst_blocked", 64'(bus.out_blocked), 64'(0));
    chk("donerst_any", 64'(bus.out_any), 64'(0));
    step();
    rst = 1'b0;
    step();
    chk("donerst_ready", 64'(bus.pt_ready), 64'(1));

    // Abort coinciding with the last code's accept.
    fq = '{15'h0011, 15'h0022};
    send_codes(1'b0, 1'b0);
    bus.pt_valid = 1'b1;
    bus.pt_code  = 15'h0044;
    bus.pt_last  = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
    chk("abort_ready", 64'(bus.pt_ready), 64'(1));
    chk("abort_chk_code", 64'(bus.chk_code), 64'(15'h0022));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_result", 64'(bus.out_valid), 64'(0));
    end
    fq = '{15'h0008};
    run_frame(0, 1'b0);

    // Counter saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      sbus.pt_valid = 1'b1;
      sbus.pt_code  = 15'(1 << i);
      sbus.pt_last  = (i == 4);
      step();
    end
    sbus.pt_valid = 1'b0;
    sbus.pt_last  = 1'b0;
    step();
    step();
    chk("sat_valid", 64'(sbus.out_valid), 64'(1));
    chk("sat_count", 64'(sbus.out_count), 64'(3));
    chk("sat_blocked", 64'(sbus.out_blocked), 64'(8'h1F));
    sbus.out_ready = 1'b1;
    step();
    sbus.out_ready = 1'b0;
    chk("sat_rel_valid", 64'(sbus.out_valid), 64'(0));

    // Randomized frames with idle gaps and random backpressure.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 6);
      fq.delete();
      for (int i = 0; i < n; i++) fq.push_back(15'($urandom));
      run_frame($urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
